// File: rtl/wb_ram_wb_if_pkg.sv
// ============================================================================
// Module   : wb_ram_wb_if_pkg
// Brief    : Wishbone cycle/burst type codes and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_ram_wb_if_pkg;

  typedef logic [2:0] cti_t;
  typedef logic [1:0] bte_t;

  localparam cti_t CTI_CLASSIC = 3'b000;
  localparam cti_t CTI_CONST   = 3'b001;
  localparam cti_t CTI_INC     = 3'b010;
  localparam cti_t CTI_END     = 3'b111;

  localparam bte_t BTE_LIN     = 2'b00;
  localparam bte_t BTE_WRAP4   = 2'b01;
  localparam bte_t BTE_WRAP8   = 2'b10;
  localparam bte_t BTE_WRAP16  = 2'b11;

  localparam int         STATE_W = 2;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT  = 2'd1;
  localparam logic [1:0] S_ERR   = 2'd2;

  // Reserved CTI codes fall through as classic cycles.
  function automatic logic cti_is_burst(input cti_t cti);
    return (cti == CTI_CONST) || (cti == CTI_INC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ram_wb_if_if.sv
// ============================================================================
// Module   : wb_ram_wb_if_if
// Brief    : Wishbone slave bus plus dual-address RAM port bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_ram_wb_if_if #(
  parameter int WB_AW  = 32,
  parameter int RAM_AW = 8
);
  logic [WB_AW-1:0]  wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [3:0]        wb_sel_i;
  logic              wb_we_i;
  logic [2:0]        wb_cti_i;
  logic [1:0]        wb_bte_i;
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_ack_o;
  logic              wb_err_o;
  logic [31:0]       wb_dat_o;
  logic [3:0]        ram_we_o;
  logic [RAM_AW-1:0] ram_waddr_o;
  logic [RAM_AW-1:0] ram_raddr_o;
  logic [31:0]       ram_din_o;
  logic [31:0]       ram_dout_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i,
           wb_cyc_i, wb_stb_i, ram_dout_i,
    output wb_ack_o, wb_err_o, wb_dat_o, ram_we_o, ram_waddr_o,
           ram_raddr_o, ram_din_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i,
           wb_cyc_i, wb_stb_i, ram_dout_i,
    input  wb_ack_o, wb_err_o, wb_dat_o, ram_we_o, ram_waddr_o,
           ram_raddr_o, ram_din_o
  );
endinterface

`default_nettype wire

// File: rtl/wb_ram_wb_if_burst_nxt.sv
// ============================================================================
// Module   : wb_burst_nxt_adr
// Brief    : Combinational next word address for Wishbone const/incr bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_burst_nxt_adr
  import wb_ram_wb_if_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic [AW-1:0] word,
  input  cti_t          cti,
  input  bte_t          bte,
  output logic [AW-1:0] nxt
);

  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_mask;

  assign w_inc = word + AW'(1);

  // Bits under the mask take the incremented value, the rest are held.
  always_comb begin
    w_mask = '1;
    case (bte)
      BTE_WRAP4:  w_mask = AW'(3);
      BTE_WRAP8:  w_mask = AW'(7);
      BTE_WRAP16: w_mask = AW'(15);
      default:    w_mask = '1;
    endcase
    if (cti == CTI_CONST)
      nxt = word;
    else
      nxt = (word & ~w_mask) | (w_inc & w_mask);
  end

endmodule

`default_nettype wire

// File: rtl/wb_ram_wb_if.sv
// ============================================================================
// Module   : wb_ram_wb_if
// Brief    : Wishbone B3 burst slave driving a 1-cycle-read dual-address RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_ram_wb_if
  import wb_ram_wb_if_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WB_AW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_ram_wb_if_if.slave   bus
);

  localparam int RAM_AW = $clog2(DEPTH);

  logic [STATE_W-1:0] r_state;
  logic               r_ack;
  logic               r_err;
  logic [RAM_AW-1:0]  r_rd_adr;

  logic [STATE_W-1:0] w_state_nxt;
  logic               w_ack_nxt;
  logic               w_err_nxt;
  logic [RAM_AW-1:0]  w_rd_adr_nxt;
  logic [RAM_AW-1:0]  w_raddr;
  logic [RAM_AW-1:0]  w_word;
  logic [RAM_AW-1:0]  w_nxt;
  logic               w_req;
  logic               w_oor;
  logic               w_burst;
  logic               w_adr_ok;
  logic               w_ack;

  assign w_req    = bus.wb_cyc_i & bus.wb_stb_i;
  assign w_word   = bus.wb_adr_i[RAM_AW+1:2];
  assign w_oor    = |bus.wb_adr_i[WB_AW-1:RAM_AW+2];
  assign w_burst  = cti_is_burst(bus.wb_cti_i);
  // Reads must match the word whose data is on the RAM output this cycle.
  assign w_adr_ok = !w_oor && (bus.wb_we_i || (w_word == r_rd_adr));

  wb_burst_nxt_adr #(
    .AW (RAM_AW)
  ) u_nxt (
    .word (w_word),
    .cti  (bus.wb_cti_i),
    .bte  (bus.wb_bte_i),
    .nxt  (w_nxt)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    w_rd_adr_nxt = r_rd_adr;
    w_raddr      = w_word;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_oor) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_ERR;
          end else begin
            w_ack_nxt    = 1'b1;
            w_rd_adr_nxt = w_word;
            w_state_nxt  = S_BEAT;
          end
        end
      end
      S_BEAT: begin
        if (w_req && w_adr_ok && w_burst) begin
          w_ack_nxt    = 1'b1;
          w_rd_adr_nxt = w_nxt;
          w_raddr      = w_nxt;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rd_adr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_rd_adr <= w_rd_adr_nxt;
    end
  end

  assign w_ack           = r_ack & w_req & w_adr_ok;
  assign bus.wb_ack_o    = w_ack;
  assign bus.wb_err_o    = r_err & w_req;
  assign bus.wb_dat_o    = bus.ram_dout_i;
  assign bus.ram_we_o    = bus.wb_sel_i & {4{w_ack & bus.wb_we_i}};
  assign bus.ram_waddr_o = w_word;
  assign bus.ram_raddr_o = w_raddr;
  assign bus.ram_din_o   = bus.wb_dat_i;

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_wb_if.sv
// ============================================================================
// Module   : tb_wb_ram_wb_if
// Brief    : Scoreboard bench for wb_ram_wb_if with a 1-cycle-read RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_ram_wb_if;
  import wb_ram_wb_if_pkg::*;

  localparam int DEPTH  = 256;
  localparam int WB_AW  = 32;
  localparam int RAM_AW = 8;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  wb_ram_wb_if_if #(.WB_AW(WB_AW), .RAM_AW(RAM_AW)) bus ();

  wb_ram_wb_if #(.DEPTH(DEPTH), .WB_AW(WB_AW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  // Word i starts as {4{i}} so untouched locations have known contents.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {4{8'(i)}};
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) mem[bus.ram_waddr_o][8*b +: 8] <= bus.ram_din_o[8*b +: 8];
    end
    bus.ram_dout_i <= mem[bus.ram_raddr_o];
  end

  typedef struct {
    string       nm;
    logic        ack;
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
    logic [3:0]  we;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "ack", 32'(bus.wb_ack_o), 32'(e.ack));
        chk(e.nm, "err", 32'(bus.wb_err_o), 32'(e.err));
        chk(e.nm, "ram_we", 32'(bus.ram_we_o), 32'(e.we));
        if (e.chk_dat) chk(e.nm, "dat_o", bus.wb_dat_o, e.dat);
      end
    end
  end

  task automatic drive(input string nm, input logic r, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input cti_t cti, input bte_t bte,
                       input logic e_ack, input logic e_err, input logic [31:0] e_dat);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    bus.wb_cyc_i = cyc;
    bus.wb_stb_i = cyc;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = dat;
    bus.wb_sel_i = sel;
    bus.wb_cti_i = cti;
    bus.wb_bte_i = bte;
    e.nm      = nm;
    e.ack     = e_ack;
    e.err     = e_err;
    e.chk_dat = e_ack & ~we;
    e.dat     = e_dat;
    e.we      = (e_ack && we) ? sel : 4'h0;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm);
    drive(nm, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LIN, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input string nm, input logic [31:0] adr, input cti_t cti, input bte_t bte,
                    input logic e_ack, input logic [31:0] e_dat);
    drive(nm, 1'b0, 1'b1, 1'b0, adr, 32'h0, 4'hF, cti, bte, e_ack, 1'b0, e_dat);
  endtask

  task automatic wr(input string nm, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input cti_t cti, input bte_t bte, input logic e_ack);
    drive(nm, 1'b0, 1'b1, 1'b1, adr, dat, sel, cti, bte, e_ack, 1'b0, 32'h0);
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;
    bus.wb_cti_i = '0;   bus.wb_bte_i = '0;

    drive("reset0", 1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0, 1'b0, 32'h0);
    mem_init = 1'b0;
    drive("reset1", 1'b1, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0, 1'b0, 32'h0);
    idle("post_reset");

    // Classic write: one wait state, single ack, none on the following cycle.
    wr("t1_wait", 32'h10, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0);
    wr("t1_ack",  32'h10, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b1);
    wr("t1_c2",   32'h10, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0);
    idle("t1_idle");

    rd("t2_rd_wait", 32'h10, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t2_rd_ack",  32'h10, CTI_CLASSIC, BTE_LIN, 1'b1, 32'hDEADBEEF);
    wr("t2_wr_wait", 32'h10, 32'h0000AB00, 4'b0010, CTI_CLASSIC, BTE_LIN, 1'b0);
    wr("t2_wr_ack",  32'h10, 32'h0000AB00, 4'b0010, CTI_CLASSIC, BTE_LIN, 1'b1);
    rd("t2_rb_wait", 32'h10, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t2_rb_ack",  32'h10, CTI_CLASSIC, BTE_LIN, 1'b1, 32'hDEADABEF);
    idle("t2_idle");

    // Wrap4 read burst from word 14: 14,15,12,13.
    rd("t3_wait", 32'h38, CTI_INC, BTE_WRAP4, 1'b0, 32'h0);
    rd("t3_b0",   32'h38, CTI_INC, BTE_WRAP4, 1'b1, 32'h0E0E0E0E);
    rd("t3_b1",   32'h3C, CTI_INC, BTE_WRAP4, 1'b1, 32'h0F0F0F0F);
    rd("t3_b2",   32'h30, CTI_INC, BTE_WRAP4, 1'b1, 32'h0C0C0C0C);
    rd("t3_b3",   32'h34, CTI_END, BTE_WRAP4, 1'b1, 32'h0D0D0D0D);
    idle("t3_idle");

    // Linear write burst across the top of memory: 254,255,0.
    wr("t4_wait", 32'h3F8, 32'h11111111, 4'hF, CTI_INC, BTE_LIN, 1'b0);
    wr("t4_b0",   32'h3F8, 32'h11111111, 4'hF, CTI_INC, BTE_LIN, 1'b1);
    wr("t4_b1",   32'h3FC, 32'h22222222, 4'hF, CTI_INC, BTE_LIN, 1'b1);
    wr("t4_b2",   32'h000, 32'h33333333, 4'hF, CTI_END, BTE_LIN, 1'b1);
    idle("t4_idle");
    rd("t4_rb254_wait", 32'h3F8, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t4_rb254_ack",  32'h3F8, CTI_CLASSIC, BTE_LIN, 1'b1, 32'h11111111);
    rd("t4_rb255_wait", 32'h3FC, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t4_rb255_ack",  32'h3FC, CTI_CLASSIC, BTE_LIN, 1'b1, 32'h22222222);
    rd("t4_rb0_wait",   32'h000, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t4_rb0_ack",    32'h000, CTI_CLASSIC, BTE_LIN, 1'b1, 32'h33333333);
    idle("t4_idle2");

    // Out-of-range read and write: single-cycle err, never a RAM write.
    rd("t5_rd_wait", 32'h400, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    drive("t5_rd_err", 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0, 1'b1, 32'h0);
    idle("t5_idle0");
    wr("t5_wr_wait", 32'h404, 32'hFFFFFFFF, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0);
    drive("t5_wr_err", 1'b0, 1'b1, 1'b1, 32'h404, 32'hFFFFFFFF, 4'hF, CTI_CLASSIC, BTE_LIN, 1'b0, 1'b1, 32'h0);
    idle("t5_idle1");
    rd("t5_ok_wait", 32'h10, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t5_ok_ack",  32'h10, CTI_CLASSIC, BTE_LIN, 1'b1, 32'hDEADABEF);
    idle("t5_idle2");

    // Async reset on the second beat of a write burst.
    wr("t6_wait", 32'h40, 32'hCAFE0001, 4'hF, CTI_INC, BTE_LIN, 1'b0);
    wr("t6_b0",   32'h40, 32'hCAFE0001, 4'hF, CTI_INC, BTE_LIN, 1'b1);
    drive("t6_b1_rst", 1'b1, 1'b1, 1'b1, 32'h44, 32'hCAFE0002, 4'hF, CTI_INC, BTE_LIN, 1'b0, 1'b0, 32'h0);
    idle("t6_after_rst");
    rd("t6_rd17_wait", 32'h44, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t6_rd17_ack",  32'h44, CTI_CLASSIC, BTE_LIN, 1'b1, 32'h11111111);
    rd("t6_rd16_wait", 32'h40, CTI_CLASSIC, BTE_LIN, 1'b0, 32'h0);
    rd("t6_rd16_ack",  32'h40, CTI_CLASSIC, BTE_LIN, 1'b1, 32'hCAFE0001);
    idle("t6_idle");

    // Master jumps address mid-burst: jump beat unacked, then re-issued.
    rd("t7_wait",  32'h00, CTI_INC, BTE_LIN, 1'b0, 32'h0);
    rd("t7_b0",    32'h00, CTI_INC, BTE_LIN, 1'b1, 32'h33333333);
    rd("t7_jump",  32'h20, CTI_INC, BTE_LIN, 1'b0, 32'h0);
    rd("t7_rwait", 32'h20, CTI_INC, BTE_LIN, 1'b0, 32'h0);
    rd("t7_re",    32'h20, CTI_END, BTE_LIN, 1'b1, 32'h08080808);
    idle("t7_idle");

    // Constant-address burst holds the word.
    rd("t8_wait", 32'h10, CTI_CONST, BTE_LIN, 1'b0, 32'h0);
    rd("t8_b0",   32'h10, CTI_CONST, BTE_LIN, 1'b1, 32'hDEADABEF);
    rd("t8_b1",   32'h10, CTI_END,   BTE_LIN, 1'b1, 32'hDEADABEF);
    idle("t8_idle");

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
